// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
// Shift-add multiply / restoring divide on magnitudes, then a sign-fix step.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q;
   logic [XLEN-1:0]     a_q, b_q, result_q;
   logic                neg_q, special_q;
   logic [CW-1:0]       cnt_q;
   logic [2*XLEN-1:0]   acc_q, acc_step, acc_special;

   logic            accept, sgn_a, sgn_b, sa, sb, neg_in, div0, ovf, special_in;
   logic [XLEN-1:0] a_mag, b_mag;

   assign accept = (state_q == IDLE) && start && !flush;
   assign sgn_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
   assign sgn_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
   assign sa     = sgn_a && A[XLEN-1];
   assign sb     = sgn_b && B[XLEN-1];
   assign a_mag  = sa ? -A : A;
   assign b_mag  = sb ? -B : B;
   // REM and MULHSU follow the dividend / rs1 sign only
   assign neg_in = ((op == 3'b110) || (op == 3'b010)) ? sa : (sa ^ sb);
   assign div0   = op[2] && (B == '0);
   assign ovf    = ((op == 3'b100) || (op == 3'b110)) && (A == MIN_NEG) && (B == ALL_ONES);
   assign special_in = div0 || ovf;

   logic [XLEN:0]   mul_sum, rem_sh;
   logic [XLEN+1:0] rem_diff;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
      rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
      if (op_q[2]) begin
         if (!rem_diff[XLEN+1])
            acc_step = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         else
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   // special cases park {remainder, quotient} in acc so the normal fix step selects them
   assign acc_special = (b_q == '0) ? {a_q, ALL_ONES} : {{XLEN{1'b0}}, MIN_NEG};

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fixed;

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (op_q[2])
         fixed = op_q[1] ? rem_fix : quo_fix;
      else
         fixed = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = special_in ? FIX : CALC;
         CALC: begin
            if (flush)                          state_d = IDLE;
            else if (cnt_q == CW'(XLEN - 1))    state_d = FIX;
         end
         FIX: begin
            if (flush)          state_d = IDLE;
            else if (!special_q) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      stall  = accept || (state_q == CALC) || (state_q == FIX);
      result = result_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         result_q  <= '0;
      end else if (accept) begin
         op_q      <= op;
         special_q <= special_in;
         neg_q     <= special_in ? 1'b0 : neg_in;
         cnt_q     <= '0;
         a_q       <= special_in ? A : a_mag;
         b_q       <= special_in ? B : b_mag;
         acc_q     <= special_in ? '0 : {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
      end else if (state_q == CALC && !flush) begin
         cnt_q <= cnt_q + 1'b1;
         acc_q <= acc_step;
      end else if (state_q == FIX && !flush) begin
         if (special_q) begin
            acc_q     <= acc_special;
            special_q <= 1'b0;
         end else begin
            result_q <= fixed;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
// Cycle k is sampled at the falling edge after accepting edge k.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        flush;
   logic        stall, busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_seq #(.XLEN(32)) dut (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // issues one op from a falling edge; operands are scrambled mid-run to prove they are latched
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int          dc;
      int          stalls;
      logic [31:0] res;
      dc = -1;
      stalls = 0;
      res = 32'hDEADBEEF;
      start = 1'b1; op = o; A = a; B = b;
      #1 check({tag, ".stall_acc"}, {31'd0, stall}, 32'd1);
      @(posedge clk);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 3) begin
            A = ~A;
            B = B + 32'd1;
         end
         if (stall) stalls++;
         if (done) begin
            dc = k;
            res = result;
            break;
         end
      end
      start = 1'b0;
      check({tag, ".done_cycle"}, dc, exp_lat);
      check({tag, ".stall_cycles"}, stalls, exp_lat);
      check({tag, ".result"}, res, exp_res);
      @(negedge clk);
      check({tag, ".done_pulse"}, {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      int dseen;
      rstn = 1'b0; start = 1'b0; op = 3'b000; A = '0; B = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {28'd0, stall, busy, done, 1'b0}, 32'd0);
      check("reset_result", result, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhu",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);

      // asynchronous reset in cycle 20 of a MUL
      start = 1'b1; op = 3'b000; A = 32'd3; B = 32'd5;
      @(posedge clk);
      dseen = 0;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      start = 1'b0;
      rstn = 1'b0;
      #1;
      check("rst_mid.outputs", {28'd0, stall, busy, done, 1'b0}, 32'd0);
      check("rst_mid.result", result, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done) dseen++;
      end
      check("rst_mid.no_done", dseen, 0);

      run_op("divu", 3'b101, 32'd100,       32'd7, 32'd14,       33);
      run_op("remu", 3'b111, 32'd100,       32'd7, 32'd2,        33);

      // flush while idle beats start
      start = 1'b1; flush = 1'b1; op = 3'b000; A = 32'd2; B = 32'd2;
      #1 check("flush_idle.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      check("flush_idle.busy", {31'd0, busy}, 32'd0);
      start = 1'b0; flush = 1'b0;

      // flush in cycle 10 of a DIVU
      start = 1'b1; op = 3'b101; A = 32'd1000; B = 32'd3;
      @(posedge clk);
      dseen = 0;
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (done) dseen++;
      end
      flush = 1'b1; start = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      if (done) dseen++;
      check("flush_calc.busy", {31'd0, busy}, 32'd0);
      check("flush_calc.no_done", dseen, 0);
      check("flush_calc.result_held", result, 32'd2);
      run_op("divu_after_flush", 3'b101, 32'd100, 32'd7, 32'd14, 33);

      run_op("div_neg",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_neg",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("div_by0",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
      run_op("rem_by0",  3'b110, 32'd5,        32'd0,        32'd5,        2);
      run_op("divu_by0", 3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 2);
      run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
      run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
